// File: rtl/dtcm_responder.sv
// Fixed-latency DTCM responder for the D-cache request/response interface.
// Optional completed-access counters: define CERES_DTCM_PERF_EN.
package dtcm_pkg;
    typedef enum logic [1:0] {
        NO_SIZE = 2'd0,
        BYTE    = 2'd1,
        HALF    = 2'd2,
        WORD    = 2'd3
    } rw_size_t;

    typedef struct packed {
        logic        valid;
        logic        ready;
        logic [31:0] addr;
        logic        rw;
        rw_size_t    rw_size;
        logic [31:0] data;
        logic        uncached;
    } dcache_req_t;

    typedef struct packed {
        logic        valid;
        logic        ready;
        logic        miss;
        logic [31:0] data;
    } dcache_res_t;
endpackage

module dtcm_responder
    import dtcm_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int unsigned LATENCY   = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  dcache_req_t dcache_req_i,
    output dcache_res_t dcache_res_o,
    output logic        busy_o,
    output logic        err_o,
    output logic [31:0] ld_cnt_o,
    output logic [31:0] st_cnt_o
);
    localparam int unsigned IDX_W    = $clog2(MEM_WORDS);
    localparam logic [32:0] END_ADDR = 33'(BASE_ADDR) + 33'(4 * MEM_WORDS);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state_q;
    logic [3:0]  lat_q;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic        rw_q;
    rw_size_t    size_q;
    logic        res_valid_q;
    logic [31:0] res_data_q;
    logic        err_q;
    logic        busy_q;

    logic [31:0] mem [MEM_WORDS];

    logic             enter_resp;
    logic             consume;
    logic [31:0]      cur_addr;
    logic [31:0]      cur_data;
    logic             cur_rw;
    rw_size_t         cur_size;
    logic             illegal;
    logic [IDX_W-1:0] idx;
    logic [3:0]       mask;
    logic [31:0]      wdata;
    logic             we;
    logic             unused_ok;

    assign unused_ok = dcache_req_i.uncached;

    // The array access happens on the edge entering RESP, so data is already
    // registered for the first RESP cycle; one outstanding access keeps
    // store-then-load ordering intact.
    assign enter_resp = (state_q == IDLE && dcache_req_i.valid && LATENCY == 1) ||
                        (state_q == WAIT && lat_q == 4'd1);
    assign consume    = (state_q == RESP) && dcache_req_i.ready;

    always_comb begin
        cur_addr = addr_q;
        cur_data = data_q;
        cur_rw   = rw_q;
        cur_size = size_q;
        if (state_q == IDLE) begin
            cur_addr = dcache_req_i.addr;
            cur_data = dcache_req_i.data;
            cur_rw   = dcache_req_i.rw;
            cur_size = dcache_req_i.rw_size;
        end
    end

    assign illegal = ({1'b0, cur_addr} < 33'(BASE_ADDR)) ||
                     ({1'b0, cur_addr} >= END_ADDR) ||
                     (cur_size == NO_SIZE) ||
                     (cur_size == HALF && cur_addr[0]) ||
                     (cur_size == WORD && cur_addr[1:0] != 2'b00);
    assign idx = cur_addr[IDX_W+1:2];
    assign we  = enter_resp && cur_rw && !illegal;

    always_comb begin
        mask  = 4'b0000;
        wdata = '0;
        case (cur_size)
            BYTE: begin
                mask  = 4'b0001 << cur_addr[1:0];
                wdata = {24'b0, cur_data[7:0]} << {cur_addr[1:0], 3'b000};
            end
            HALF: begin
                mask  = cur_addr[1] ? 4'b1100 : 4'b0011;
                wdata = cur_addr[1] ? {cur_data[15:0], 16'b0} : {16'b0, cur_data[15:0]};
            end
            WORD: begin
                mask  = 4'b1111;
                wdata = cur_data;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (we) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (mask[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            lat_q       <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            rw_q        <= 1'b0;
            size_q      <= NO_SIZE;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            err_q <= enter_resp && illegal;
            case (state_q)
                IDLE: begin
                    if (dcache_req_i.valid) begin
                        addr_q  <= dcache_req_i.addr;
                        data_q  <= dcache_req_i.data;
                        rw_q    <= dcache_req_i.rw;
                        size_q  <= dcache_req_i.rw_size;
                        lat_q   <= 4'(LATENCY - 1);
                        busy_q  <= 1'b1;
                        state_q <= (LATENCY == 1) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    lat_q <= lat_q - 4'd1;
                    if (lat_q == 4'd1) state_q <= RESP;
                end
                RESP: begin
                    if (dcache_req_i.ready) begin
                        state_q     <= IDLE;
                        res_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
            if (enter_resp) begin
                res_valid_q <= 1'b1;
                res_data_q  <= (cur_rw || illegal) ? '0 : mem[idx];
            end
        end
    end

    always_comb begin
        dcache_res_o       = '0;
        dcache_res_o.valid = res_valid_q;
        dcache_res_o.data  = res_data_q;
    end

    assign busy_o = busy_q;
    assign err_o  = err_q;

`ifdef CERES_DTCM_PERF_EN
    logic [31:0] ld_cnt_q;
    logic [31:0] st_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ld_cnt_q <= '0;
            st_cnt_q <= '0;
        end else if (consume) begin
            if (rw_q) st_cnt_q <= st_cnt_q + 32'd1;
            else      ld_cnt_q <= ld_cnt_q + 32'd1;
        end
    end

    assign ld_cnt_o = ld_cnt_q;
    assign st_cnt_o = st_cnt_q;
`else
    logic unused_consume;
    assign unused_consume = consume;
    assign ld_cnt_o = '0;
    assign st_cnt_o = '0;
`endif

endmodule

// File: tb/tb_dtcm_responder.sv
// Randomized bench for dtcm_responder against a byte-level memory model.
module tb_dtcm_responder;
    import dtcm_pkg::*;

    localparam int unsigned MW   = 64;
    localparam int unsigned LAT  = 2;
    localparam logic [31:0] BASE = 32'h8000_0000;
`ifdef CERES_DTCM_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    dcache_req_t req;
    dcache_res_t res;
    logic        busy, err;
    logic [31:0] ld_cnt, st_cnt;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic [31:0] mdl [MW];
    int unsigned ld_n = 0;
    int unsigned st_n = 0;

    always #5 clk = ~clk;

    dtcm_responder #(.MEM_WORDS(MW), .BASE_ADDR(BASE), .LATENCY(LAT)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .dcache_req_i(req), .dcache_res_o(res),
        .busy_o(busy), .err_o(err), .ld_cnt_o(ld_cnt), .st_cnt_o(st_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit is_legal(input logic [31:0] a, input rw_size_t sz);
        if (a < BASE || (a - BASE) >= 4 * MW) return 1'b0;
        if (sz == NO_SIZE) return 1'b0;
        if (sz == HALF && (a % 2) != 0) return 1'b0;
        if (sz == WORD && (a % 4) != 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic void mdl_store(input logic [31:0] a, input logic [31:0] d, input rw_size_t sz);
        int unsigned w, nb, b;
        w  = (a - BASE) / 4;
        nb = (sz == BYTE) ? 1 : (sz == HALF) ? 2 : 4;
        for (int unsigned i = 0; i < nb; i++) begin
            b = (a % 4) + i;
            mdl[w] = (mdl[w] & ~(32'hFF << (8 * b))) | (((d >> (8 * i)) & 32'hFF) << (8 * b));
        end
    endfunction

    task automatic check_cnt(input string tag);
        check_eq({tag, ".ld_cnt"}, ld_cnt, PERF ? ld_n : 0);
        check_eq({tag, ".st_cnt"}, st_cnt, PERF ? st_n : 0);
    endtask

    // One full transaction: issue, latency check, optional stall with a stray request, consume.
    task automatic txn(input logic rw, input rw_size_t sz, input logic [31:0] a,
                       input logic [31:0] d, input int unsigned stall, input bit poke);
        logic [31:0] exp_data;
        bit          legal;
        int unsigned cyc;
        legal    = is_legal(a, sz);
        exp_data = (legal && !rw) ? mdl[(a - BASE) / 4] : 32'h0;
        if (legal && rw) mdl_store(a, d, sz);

        @(posedge clk); #1;
        req.valid = 1'b1; req.ready = 1'b0; req.rw = rw; req.rw_size = sz;
        req.addr = a; req.data = d; req.uncached = $urandom_range(0, 1);
        @(posedge clk); #1;
        req.valid = 1'b0;
        cyc = 1;
        while (!res.valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check_eq("latency", cyc, LAT);
        check_eq("resp.data", res.data, exp_data);
        check_eq("resp.err", err, !legal);
        check_eq("resp.busy", busy, 1);
        for (int unsigned s = 0; s < stall; s++) begin
            if (poke && s == 0) begin
                req.valid = 1'b1; req.rw = 1'b1; req.rw_size = WORD;
                req.addr = BASE; req.data = $urandom;
            end
            @(posedge clk); #1;
            req.valid = 1'b0;
            check_eq("hold.valid", res.valid, 1);
            check_eq("hold.data", res.data, exp_data);
            check_eq("hold.err", err, 0);
            check_eq("hold.busy", busy, 1);
        end
        req.ready = 1'b1;
        @(posedge clk); #1;
        req.ready = 1'b0;
        if (rw) st_n++; else ld_n++;
        check_eq("done.valid", res.valid, 0);
        check_eq("done.busy", busy, 0);
        check_cnt("done");
    endtask

    initial begin
        int unsigned hits;
        int unsigned last_cyc;
        logic [31:0] a;
        rw_size_t    sz;

        req = '0;
        #12;
        check_eq("rst.valid", res.valid, 0);
        check_eq("rst.data", res.data, 0);
        check_eq("rst.busy", busy, 0);
        check_eq("rst.err", err, 0);
        check_cnt("rst");
        @(negedge clk); rst_n = 1'b1;

        for (int unsigned w = 0; w < MW; w++) txn(1'b1, WORD, BASE + 4 * w, $urandom, 0, 1'b0);

        txn(1'b1, WORD, 32'h8000_0010, 32'hDEAD_BEEF, 0, 1'b0);
        txn(1'b0, WORD, 32'h8000_0010, 32'h0, 0, 1'b0);
        check_eq("sw_lw.model", mdl[4], 32'hDEAD_BEEF);

        txn(1'b1, WORD, 32'h8000_0020, 32'h0, 0, 1'b0);
        txn(1'b1, BYTE, 32'h8000_0021, 32'hFFFF_FFAA, 0, 1'b0);
        txn(1'b1, HALF, 32'h8000_0022, 32'hFFFF_1234, 1, 1'b0);
        check_eq("merge.model", mdl[8], 32'h1234_AA00);
        txn(1'b0, WORD, 32'h8000_0020, 32'h0, 0, 1'b0);

        txn(1'b0, WORD, 32'h8000_0010, 32'h0, 3, 1'b1);

        txn(1'b1, WORD, 32'h8000_0002, 32'h5555_5555, 2, 1'b0);
        txn(1'b0, WORD, 32'h8000_0000, 32'h0, 0, 1'b0);
        txn(1'b0, WORD, 32'h7FFF_FFFC, 32'h0, 0, 1'b0);
        txn(1'b0, WORD, BASE + 4 * MW, 32'h0, 0, 1'b0);
        txn(1'b0, WORD, BASE + 4 * MW - 4, 32'h0, 0, 1'b0);
        txn(1'b1, NO_SIZE, 32'h8000_0004, 32'h0, 0, 1'b0);
        txn(1'b1, HALF, 32'h8000_0005, 32'h0, 0, 1'b0);

        for (int unsigned n = 0; n < 80; n++) begin
            case ($urandom_range(0, 9))
                0:       a = BASE - 4 + $urandom_range(0, 3);
                1:       a = BASE + 4 * MW + $urandom_range(0, 15);
                default: a = BASE + $urandom_range(0, 4 * MW - 1);
            endcase
            if ($urandom_range(0, 1) == 1) a = a & ~32'h3;
            sz = ($urandom_range(0, 9) == 0) ? NO_SIZE : rw_size_t'($urandom_range(1, 3));
            txn($urandom_range(0, 1), sz, a, $urandom, $urandom_range(0, 2), $urandom_range(0, 1));
        end

        // Back-to-back loads with request and ready held high.
        @(posedge clk); #1;
        req.valid = 1'b1; req.ready = 1'b1; req.rw = 1'b0; req.rw_size = WORD; req.addr = BASE + 8;
        hits = 0; last_cyc = 0;
        for (int unsigned c = 1; c <= 40 && hits < 4; c++) begin
            @(posedge clk); #1;
            if (res.valid) begin
                if (hits > 0) check_eq("b2b.period", c - last_cyc, LAT + 1);
                check_eq("b2b.data", res.data, mdl[2]);
                last_cyc = c;
                hits++;
                if (hits == 4) req.valid = 1'b0;
            end
        end
        check_eq("b2b.count", hits, 4);
        ld_n += hits;
        @(posedge clk); #1;
        req.ready = 1'b0;
        check_eq("b2b.busy", busy, 0);
        check_cnt("b2b");

        // Reset during WAIT: store must not land.
        @(posedge clk); #1;
        req.valid = 1'b1; req.rw = 1'b1; req.rw_size = WORD; req.addr = BASE + 20; req.data = ~mdl[5];
        @(posedge clk); #1;
        req.valid = 1'b0;
        check_eq("rstw.busy_before", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("rstw.valid", res.valid, 0);
        check_eq("rstw.busy", busy, 0);
        @(posedge clk); @(negedge clk); rst_n = 1'b1;
        ld_n = 0; st_n = 0;
        check_cnt("rstw");
        txn(1'b0, WORD, BASE + 20, 32'h0, 0, 1'b0);

        // Reset during RESP drops valid without waiting for a clock.
        @(posedge clk); #1;
        req.valid = 1'b1; req.rw = 1'b0; req.rw_size = WORD; req.addr = BASE + 24;
        @(posedge clk); #1;
        req.valid = 1'b0;
        for (int unsigned c = 0; c < 20 && !res.valid; c++) begin
            @(posedge clk); #1;
        end
        check_eq("rstr.valid_before", res.valid, 1);
        rst_n = 1'b0;
        #1;
        check_eq("rstr.valid", res.valid, 0);
        check_eq("rstr.data", res.data, 0);
        check_eq("rstr.busy", busy, 0);
        @(negedge clk); rst_n = 1'b1;
        ld_n = 0; st_n = 0;
        check_cnt("rstr");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
